// File: rtl/count_pwm_driver.sv
// count_pwm_driver
//   Turns the 4-bit free-running counter value into LED brightness. duty_in is
//   used as a 16-step PWM duty cycle; each step lasts PRESCALE clocks, so a
//   frame is 16*PRESCALE clocks. The counter's 15->0 wrap is also flagged and
//   counted for the LEDR bank.
//
// Parameters
//   PRESCALE  clk cycles per PWM step (1..65535)
//   WRAPW     width of the wrap event counter
//
// Ports
//   clk          in   system clock
//   rstn         in   asynchronous active-low reset
//   en           in   run enable; low freezes the PWM engine and blanks the LED
//   duty_in[3:0] in   upstream count value, used as the duty
//   pwm_out      out  registered LED drive
//   frame_start  out  one-cycle pulse as a new 16-step frame begins
//   wrap_pulse   out  one-cycle pulse after a 15->0 step on duty_in
//   wrap_count   out  wraps since reset, saturating at all-ones

module count_pwm_driver #(
   parameter int PRESCALE = 3125,
   parameter int WRAPW    = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [3:0]       duty_in,
   output logic             pwm_out,
   output logic             frame_start,
   output logic             wrap_pulse,
   output logic [WRAPW-1:0] wrap_count
);

   localparam int             PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

   logic [PSW-1:0] prescaler;
   logic [3:0]     phase;
   logic [3:0]     duty_q;
   logic [3:0]     prev_duty;
   logic           tick;
   logic           frame_end;
   logic           wrap_det;

   assign tick      = en && (prescaler == PS_LAST);
   assign frame_end = tick && (phase == 4'hF);
   assign wrap_det  = (prev_duty == 4'hF) && (duty_in == 4'h0);

   // Step timer: advances only while enabled, so a paused frame resumes
   // exactly where it stopped.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prescaler <= '0;
      end else if (en) begin
         if (tick) prescaler <= '0;
         else      prescaler <= prescaler + PSW'(1);
      end
   end

   // Phase and frame boundary. duty_q only changes at the boundary so the
   // LED never sees a torn frame when the counter moves mid-frame.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         phase       <= 4'h0;
         duty_q      <= 4'h0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= frame_end;
         if (tick) phase <= phase + 4'h1;
         if (frame_end) duty_q <= duty_in;
      end
   end

   // phase < duty_q caps the duty at 15/16; full-on is not reachable.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pwm_out <= 1'b0;
      end else begin
         pwm_out <= en && (phase < duty_q);
      end
   end

   // Wrap detection ignores en. prev_duty resets to 0, so a 15 before reset
   // followed by 0 after it is not reported as a wrap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prev_duty  <= 4'h0;
         wrap_pulse <= 1'b0;
         wrap_count <= '0;
      end else begin
         prev_duty  <= duty_in;
         wrap_pulse <= wrap_det;
         if (wrap_det && (wrap_count != {WRAPW{1'b1}}))
            wrap_count <= wrap_count + WRAPW'(1);
      end
   end

endmodule

// File: tb/tb_count_pwm_driver.sv
module tb_count_pwm_driver;

   localparam int P_A     = 2;
   localparam int FRAME_A = 16 * P_A;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       en = 1'b1;
   logic [3:0] duty_in = 4'd4;

   logic       pwm_a, fs_a, wp_a;
   logic [7:0] wc_a;
   logic       pwm_b, fs_b, wp_b;
   logic [1:0] wc_b;

   int errors = 0;
   int checks = 0;

   logic [10:0] sb_q[$];

   int         m_cnt  = 0;
   logic [3:0] m_duty = 4'd0;
   logic [3:0] m_prev = 4'd0;
   logic [7:0] m_wc   = 8'd0;

   count_pwm_driver #(.PRESCALE(P_A), .WRAPW(8)) dut_a (
      .clk(clk), .rstn(rstn), .en(en), .duty_in(duty_in),
      .pwm_out(pwm_a), .frame_start(fs_a), .wrap_pulse(wp_a), .wrap_count(wc_a)
   );

   count_pwm_driver #(.PRESCALE(1), .WRAPW(2)) dut_b (
      .clk(clk), .rstn(rstn), .en(en), .duty_in(duty_in),
      .pwm_out(pwm_b), .frame_start(fs_b), .wrap_pulse(wp_b), .wrap_count(wc_b)
   );

   always #5 clk = ~clk;

   // Reference for dut_a, tracked as a position within the frame in enabled
   // clocks; the step index is that position divided by the prescale.
   function automatic logic [10:0] model_out(input int cnt, input logic [3:0] dq,
                                              input logic [3:0] pv, input logic [7:0] wc,
                                              input logic e, input logic [3:0] d);
      logic pwm_e, bnd, wr;
      logic [7:0] wc_n;
      pwm_e = e && ((cnt / P_A) < int'(dq));
      bnd   = e && (cnt == FRAME_A - 1);
      wr    = (pv == 4'd15) && (d == 4'd0);
      wc_n  = (wr && wc != 8'hFF) ? wc + 8'd1 : wc;
      return {pwm_e, bnd, wr, wc_n};
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_cnt  <= 0;
         m_duty <= 4'd0;
         m_prev <= 4'd0;
         m_wc   <= 8'd0;
      end else begin
         sb_q.push_back(model_out(m_cnt, m_duty, m_prev, m_wc, en, duty_in));
         if (en) m_cnt <= (m_cnt == FRAME_A - 1) ? 0 : m_cnt + 1;
         if (en && m_cnt == FRAME_A - 1) m_duty <= duty_in;
         m_prev <= duty_in;
         if (m_prev == 4'd15 && duty_in == 4'd0 && m_wc != 8'hFF) m_wc <= m_wc + 8'd1;
      end
   end

   // Advance one clock and retire the oldest scoreboard entry for dut_a.
   task automatic cycle();
      logic [10:0] got, exp;
      @(negedge clk);
      got = {pwm_a, fs_a, wp_a, wc_a};
      if (sb_q.size() > 0) exp = sb_q.pop_front();
      else                 exp = '0;
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL scoreboard t=%0t got pwm=%b fs=%b wp=%b wc=%0d expected pwm=%b fs=%b wp=%b wc=%0d",
                  $time, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
      end
   endtask

   task automatic test_reset();
      #1 rstn = 1'b0;
      sb_q.delete();
      #2;
      checks++;
      if ({pwm_a, fs_a, wp_a, wc_a} !== 11'd0) begin
         errors++;
         $display("FAIL reset_a: got %b expected 0", {pwm_a, fs_a, wp_a, wc_a});
      end
      checks++;
      if ({pwm_b, fs_b, wp_b, wc_b} !== 5'd0) begin
         errors++;
         $display("FAIL reset_b: got %b expected 0", {pwm_b, fs_b, wp_b, wc_b});
      end
      cycle();
      cycle();
      rstn = 1'b1;
   endtask

   task automatic test_duty4();
      int highs, fs_at, run, maxrun;
      highs = 0; fs_at = -1;
      for (int i = 1; i <= 32; i++) begin
         cycle();
         if (pwm_a) highs++;
         if (fs_a && fs_at < 0) fs_at = i;
      end
      checks++;
      if (highs !== 0) begin errors++; $display("FAIL first_frame_dark: got %0d highs expected 0", highs); end
      checks++;
      if (fs_at !== 32) begin errors++; $display("FAIL first_frame_start: got cycle %0d expected 32", fs_at); end
      highs = 0; fs_at = -1; run = 0; maxrun = 0;
      for (int i = 33; i <= 64; i++) begin
         cycle();
         if (pwm_a) begin
            highs++; run++;
            if (run > maxrun) maxrun = run;
         end else run = 0;
         if (fs_a && fs_at < 0) fs_at = i;
      end
      checks++;
      if (highs !== 8) begin errors++; $display("FAIL duty4_highs: got %0d expected 8", highs); end
      checks++;
      if (maxrun !== 8) begin errors++; $display("FAIL duty4_run: got %0d expected 8", maxrun); end
      checks++;
      if (fs_at !== 64) begin errors++; $display("FAIL second_frame_start: got cycle %0d expected 64", fs_at); end
   endtask

   task automatic test_duty0_15();
      int highs;
      duty_in = 4'd0;
      highs = 0;
      for (int i = 0; i < 32; i++) begin cycle(); if (pwm_a) highs++; end
      checks++;
      if (highs !== 8) begin errors++; $display("FAIL duty_latched_old: got %0d expected 8", highs); end
      highs = 0;
      for (int i = 0; i < 16; i++) begin cycle(); if (pwm_a) highs++; end
      duty_in = 4'd15;
      for (int i = 0; i < 16; i++) begin cycle(); if (pwm_a) highs++; end
      checks++;
      if (highs !== 0) begin errors++; $display("FAIL duty0_midchange: got %0d highs expected 0", highs); end
      checks++;
      if (fs_a !== 1'b1) begin errors++; $display("FAIL duty0_frame_end: got fs=%b expected 1", fs_a); end
      highs = 0;
      for (int i = 0; i < 32; i++) begin cycle(); if (pwm_a) highs++; end
      checks++;
      if (highs !== 30) begin errors++; $display("FAIL duty15_highs: got %0d expected 30", highs); end
   endtask

   task automatic test_wrap();
      logic [3:0] seq1 [6] = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd1};
      logic [3:0] seq2 [3] = '{4'd15, 4'd3, 4'd3};
      int pulses, idx;
      pulses = 0; idx = -1;
      for (int i = 0; i < 6; i++) begin
         duty_in = seq1[i];
         cycle();
         if (wp_a) begin pulses++; idx = i; end
      end
      checks++;
      if (pulses !== 1 || idx !== 3) begin
         errors++; $display("FAIL wrap_single: got %0d pulses at step %0d expected 1 at step 3", pulses, idx);
      end
      checks++;
      if (wc_a !== 8'd1) begin errors++; $display("FAIL wrap_count_1: got %0d expected 1", wc_a); end
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         duty_in = seq2[i];
         cycle();
         if (wp_a) pulses++;
      end
      checks++;
      if (pulses !== 0 || wc_a !== 8'd1) begin
         errors++; $display("FAIL wrap_15_to_3: got %0d pulses count %0d expected 0 pulses count 1", pulses, wc_a);
      end
   endtask

   task automatic test_saturate();
      logic [1:0] exp_wc [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      int pulses;
      #2 rstn = 1'b0;
      sb_q.delete();
      cycle();
      cycle();
      rstn = 1'b1;
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         duty_in = 4'd15;
         cycle();
         duty_in = 4'd0;
         cycle();
         if (wp_b) pulses++;
         checks++;
         if (wc_b !== exp_wc[k]) begin
            errors++; $display("FAIL sat_count[%0d]: got %0d expected %0d", k, wc_b, exp_wc[k]);
         end
      end
      checks++;
      if (pulses !== 5) begin errors++; $display("FAIL sat_pulses: got %0d expected 5", pulses); end
      checks++;
      if (wc_a !== 8'd5) begin errors++; $display("FAIL wide_count: got %0d expected 5", wc_a); end
      duty_in = 4'd1;
      cycle();
   endtask

   task automatic test_enable();
      int n, highs, fs_cnt;
      bit found;
      duty_in = 4'd8;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         cycle();
         if (fs_a) found = 1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL en_sync: got no frame_start expected one within 100 cycles"); end
      highs = 0;
      for (int i = 0; i < 8; i++) begin cycle(); if (pwm_a) highs++; end
      en = 1'b0;
      n = 0; fs_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (pwm_a) n++;
         if (fs_a) fs_cnt++;
      end
      checks++;
      if (n !== 0 || fs_cnt !== 0) begin
         errors++; $display("FAIL en_low: got %0d highs %0d frame_starts expected 0 and 0", n, fs_cnt);
      end
      en = 1'b1;
      found = 0; n = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         cycle();
         n++;
         if (pwm_a) highs++;
         if (fs_a) found = 1;
      end
      checks++;
      if (!found || n !== 24) begin
         errors++; $display("FAIL en_resume_len: got %0d cycles (found=%0d) expected 24", n, found);
      end
      checks++;
      if (highs !== 16) begin errors++; $display("FAIL en_frame_highs: got %0d expected 16", highs); end
   endtask

   task automatic test_reset_mid();
      int highs_a, highs_b, fs_at, fsb_cnt, fsb_first;
      cycle();
      cycle();
      cycle();
      checks++;
      if (pwm_a !== 1'b1) begin errors++; $display("FAIL pre_reset_high: got %b expected 1", pwm_a); end
      #2 rstn = 1'b0;
      sb_q.delete();
      #1;
      checks++;
      if ({pwm_a, fs_a, wp_a, wc_a} !== 11'd0 || {pwm_b, fs_b, wp_b, wc_b} !== 5'd0) begin
         errors++;
         $display("FAIL async_reset: got a=%b b=%b expected all 0", {pwm_a, fs_a, wp_a, wc_a}, {pwm_b, fs_b, wp_b, wc_b});
      end
      cycle();
      cycle();
      rstn = 1'b1;
      highs_a = 0; highs_b = 0; fs_at = -1; fsb_cnt = 0; fsb_first = -1;
      for (int i = 1; i <= 32; i++) begin
         cycle();
         if (pwm_a) highs_a++;
         if (pwm_b) highs_b++;
         if (fs_a && fs_at < 0) fs_at = i;
         if (fs_b) begin
            fsb_cnt++;
            if (fsb_first < 0) fsb_first = i;
         end
      end
      checks++;
      if (highs_a !== 0) begin errors++; $display("FAIL post_reset_dark: got %0d highs expected 0", highs_a); end
      checks++;
      if (fs_at !== 32) begin errors++; $display("FAIL post_reset_frame: got cycle %0d expected 32", fs_at); end
      checks++;
      if (fsb_cnt !== 2 || fsb_first !== 16) begin
         errors++; $display("FAIL prescale1_frames: got %0d starts first at %0d expected 2 first at 16", fsb_cnt, fsb_first);
      end
      checks++;
      if (highs_b !== 8) begin errors++; $display("FAIL prescale1_highs: got %0d expected 8", highs_b); end
      highs_a = 0;
      for (int i = 0; i < 32; i++) begin cycle(); if (pwm_a) highs_a++; end
      checks++;
      if (highs_a !== 16) begin errors++; $display("FAIL post_reset_duty8: got %0d expected 16", highs_a); end
   endtask

   initial begin
      test_reset();
      test_duty4();
      test_duty0_15();
      test_wrap();
      test_saturate();
      test_enable();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/count_pwm_driver.md
Name: count_pwm_driver

Overview:
- Downstream consumer of the 4-bit free-running counter output.
- Uses the current count value as a 16-step PWM duty cycle to drive a DE10-Lite LED, so the count is visible as brightness.
- Also flags the counter's 15->0 wrap and counts wraps, for display on the LEDR bank.
- Sits between the counter's `out` bus and the board LED pins.

Parameters:
- PRESCALE, 3125: clk cycles per PWM step. 50 MHz / 3125 / 16 = 1 kHz PWM frame. Legal range 1..65535.
- WRAPW, 8: width of the wrap event counter.

Ports:
- clk  input  1  system clock (50 MHz on board).
- rstn  input  1  asynchronous active-low reset.
- en  input  1  run enable; low freezes the PWM engine.
- duty_in  input  4  count value from the upstream counter, sampled as the duty.
- pwm_out  output  1  PWM drive to LED, registered.
- frame_start  output  1  one-cycle pulse when a new 16-step frame begins.
- wrap_pulse  output  1  one-cycle pulse on a duty_in transition from 15 to 0.
- wrap_count  output  WRAPW  number of wraps since reset; saturates at all-ones.

Behaviour:
- Reset (rstn low, asynchronous):
  - Outputs: pwm_out=0, frame_start=0, wrap_pulse=0, wrap_count=0.
  - Internal: prescaler=0, phase=0, duty_q=0, prev_duty=0.
  - Holds while rstn is low. Reset mid-frame discards the frame; no partial pulse follows release.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1, then wraps to 0.
  - tick = (en && prescaler==PRESCALE-1).
  - PRESCALE=1 gives tick on every enabled cycle.
- Phase:
  - 4-bit register 0..15; increments on tick.
  - On a tick with phase==15: phase<=0, duty_q<=duty_in, frame_start<=1 for exactly one cycle. Otherwise frame_start<=0.
- Duty latching:
  - duty_q is loaded only at the frame boundary, so mid-frame changes on duty_in are glitch-free and take effect next frame.
  - After reset duty_q=0, so pwm_out stays low for the entire first frame.
- Output:
  - Every clock: pwm_out <= en && (phase < duty_q), using the pre-edge phase and duty_q. This gives one cycle of registered latency relative to phase.
  - duty_q=0 -> constantly 0.
  - duty_q=15 -> high 15 of 16 steps (100% is unreachable by design).
  - High time per frame = duty_q*PRESCALE cycles; frame length = 16*PRESCALE cycles.
- Enable:
  - en low: prescaler and phase hold their values; pwm_out is forced 0 on the next edge; no tick and no frame_start.
  - en high: resumes from the held position.
  - Wrap detection runs regardless of en.
- Wrap detection:
  - prev_duty <= duty_in every cycle.
  - wrap_pulse <= (prev_duty==15 && duty_in==0): one cycle, one cycle after the transition cycle.
  - On the same edge, wrap_count increments unless it is all-ones (saturates, no rollover).
  - Any other transition, including a 15->0 step through reset, produces no pulse: prev_duty=0 after reset.
- Simultaneous events: a frame boundary and a wrap on the same edge are independent; both update.
- duty_in is synchronous to clk; no synchronizer is needed.

Test Plan:
- PRESCALE=2, rstn low 20 ns then high, duty_in=4, en=1:
  - First 32 cycles: pwm_out=0.
  - frame_start pulses every 32 cycles.
  - Each later frame: pwm_out high exactly 8 consecutive cycles, low 24.
- PRESCALE=2, duty_in=0 then 15:
  - duty 0 frames: pwm_out never high.
  - duty 15 frames: high 30 of 32 cycles.
  - Change to 15 mid-frame: no effect until the next frame_start.
- Drive duty_in 13,14,15,0,1 on consecutive cycles:
  - Single wrap_pulse one cycle after the 0 is applied; wrap_count 0->1.
  - 15->3: no pulse.
- WRAPW=2, force 5 wraps: wrap_count reads 1,2,3,3,3; wrap_pulse still fires 5 times.
- en low for 10 cycles mid-frame:
  - pwm_out=0 and phase frozen during the low period.
  - After en high, the remaining steps complete; total frame is 32 enabled cycles.
- Assert rstn low mid-frame with duty 8:
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, the first full frame has pwm_out=0 (duty_q=0).
